// File: rtl/word_capture_16bit.sv
// word_capture_16bit
//   Assembles a stream of byte strobes (MSB first, then LSB) into 16-bit
//   words and buffers them in a small FIFO for a downstream consumer.
//
// Parameters
//   DEPTH_LOG2 : log2 of FIFO depth in 16-bit words (DEPTH = 2**DEPTH_LOG2)
//
// Ports
//   i_clk      : clock, all state changes on rising edge
//   i_rst      : asynchronous active-high reset
//   i_v_in     : byte from the processor output port
//   i_v_wr     : one-cycle strobe, i_v_in valid this cycle
//   i_sync     : forces byte phase back to MSB (discards a latched MSB)
//   o_word     : FIFO head word {MSB,LSB}; holds last value when empty
//   o_valid    : FIFO non-empty
//   i_ready    : consumer accepts o_word when o_valid is high
//   o_count    : words held, 0..DEPTH
//   o_odd      : MSB latched, LSB pending
//   o_ovf      : sticky overflow flag
//   i_clr_ovf  : clears o_ovf
//
// Build option
//   WORD_CAPTURE_16BIT_OVF_EN : when defined, o_ovf records dropped pushes
//   (set wins over i_clr_ovf); when undefined, o_ovf is tied low.
module word_capture_16bit #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_v_in,
  input  logic                  i_v_wr,
  input  logic                  i_sync,
  output logic [15:0]           o_word,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_odd,
  output logic                  o_ovf,
  input  logic                  i_clr_ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    PH_MSB = 1'b0,
    PH_LSB = 1'b1
  } phase_t;

  phase_t                phase;
  logic [7:0]            msb;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [15:0]           last_word;

  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic ovf_evt;

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    full    = 1'b0;
    wr_en   = 1'b0;
    ovf_evt = 1'b0;
    // A strobe coinciding with sync is always taken as an MSB, never a push.
    push    = i_v_wr && !i_sync && (phase == PH_LSB);
    pop     = (count != '0) && i_ready;
    full    = (count == DEPTH_CNT);
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the write lands in the slot being vacated.
    wr_en   = push && (!full || pop);
    ovf_evt = push && full && !pop;
  end

  // Byte-phase FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase <= PH_MSB;
      msb   <= '0;
    end else if (i_v_wr) begin
      if (i_sync || phase == PH_MSB) begin
        msb   <= i_v_in;
        phase <= PH_LSB;
      end else begin
        phase <= PH_MSB;
      end
    end else if (i_sync) begin
      phase <= PH_MSB;
      msb   <= '0;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {msb, i_v_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (!wr_en && pop) begin
        count <= count - 1'b1;
      end
      // Remember the visible head so o_word stays put once the FIFO drains.
      if (count != '0) begin
        last_word <= mem[rd_ptr];
      end
    end
  end

`ifdef WORD_CAPTURE_16BIT_OVF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
    end else if (ovf_evt) begin
      o_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = i_clr_ovf ^ ovf_evt;
  assign o_ovf      = 1'b0;
`endif

  assign o_valid = (count != '0);
  assign o_count = count;
  assign o_odd   = (phase == PH_LSB);
  assign o_word  = o_valid ? mem[rd_ptr] : last_word;

endmodule

// File: tb/tb_word_capture_16bit.sv
// tb_word_capture_16bit
//   Directed bench for word_capture_16bit (DEPTH_LOG2 = 3, depth 8).
//   Inputs are driven 1 time unit after the rising edge; outputs are
//   compared just before the next edge's stimulus is applied.
module tb_word_capture_16bit;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_v_in;
  logic        i_v_wr;
  logic        i_sync;
  logic [15:0] o_word;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_count;
  logic        o_odd;
  logic        o_ovf;
  logic        i_clr_ovf;

  int unsigned total;
  int unsigned bad;
  logic        ovf_exp;

  word_capture_16bit #(.DEPTH_LOG2(3)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_v_in    (i_v_in),
    .i_v_wr    (i_v_wr),
    .i_sync    (i_sync),
    .o_word    (o_word),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_count   (o_count),
    .o_odd     (o_odd),
    .o_ovf     (o_ovf),
    .i_clr_ovf (i_clr_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    i_v_in = b;
    i_v_wr = 1'b1;
    tick();
    i_v_wr = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
`ifdef WORD_CAPTURE_16BIT_OVF_EN
    ovf_exp   = 1'b1;
`else
    ovf_exp   = 1'b0;
`endif
    i_rst     = 1'b1;
    i_v_in    = '0;
    i_v_wr    = 1'b0;
    i_sync    = 1'b0;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    tick();
    tick();
    check("rst_count", o_count, 0);
    check("rst_valid", o_valid, 0);
    check("rst_odd",   o_odd,   0);
    check("rst_ovf",   o_ovf,   0);
    check("rst_word",  o_word,  16'h0000);
    i_rst = 1'b0;
    tick();

    // Basic word assembly
    strobe(8'h12);
    check("b_odd1",   o_odd,   1);
    check("b_valid0", o_valid, 0);
    strobe(8'h34);
    check("b_odd0",   o_odd,   0);
    check("b_word",   o_word,  16'h1234);
    check("b_valid",  o_valid, 1);
    check("b_count",  o_count, 1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("b_pop_count", o_count, 0);
    check("b_pop_valid", o_valid, 0);

    // Fill to full, then overflow (pointers now start at slot 1, so they wrap)
    for (int k = 0; k < 8; k++) begin
      strobe(8'(2 * k));
      strobe(8'(2 * k + 1));
    end
    check("f_count8", o_count, 8);
    check("f_head",   o_word,  16'h0001);
    check("f_ovf0",   o_ovf,   0);
    strobe(8'hAA);
    check("o_odd", o_odd, 1);
    strobe(8'hBB);
    check("o_count8", o_count, 8);
    check("o_ovf",    o_ovf,   ovf_exp);
    check("o_head",   o_word,  16'h0001);

    // Clear coinciding with a new overflow: set wins
    strobe(8'hAA);
    i_clr_ovf = 1'b1;
    strobe(8'hBB);
    i_clr_ovf = 1'b0;
    check("c_ovf_set_wins", o_ovf, ovf_exp);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    check("c_ovf_cleared", o_ovf,   0);
    check("c_count8",      o_count, 8);

    // Full with simultaneous pop and push
    strobe(8'hCA);
    check("p_head", o_word, 16'h0001);
    i_ready = 1'b1;
    strobe(8'hFE);
    i_ready = 1'b0;
    check("p_count8", o_count, 8);
    check("p_ovf0",   o_ovf,   0);

    // Drain: remaining words in order, CAFE last
    i_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check("d_word", o_word, {8'(2 * k), 8'(2 * k + 1)});
      tick();
    end
    check("d_cafe", o_word, 16'hCAFE);
    tick();
    i_ready = 1'b0;
    check("d_empty_count", o_count, 0);
    check("d_empty_valid", o_valid, 0);

    // Sync discards a pending MSB
    strobe(8'h55);
    check("s_odd1", o_odd, 1);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    check("s_odd0",   o_odd,   0);
    check("s_count0", o_count, 0);
    strobe(8'h66);
    check("s_odd1b", o_odd, 1);
    strobe(8'h77);
    check("s_count1", o_count, 1);
    check("s_word",   o_word,  16'h6677);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("s_count0b", o_count, 0);

    // Sync together with a strobe takes the byte as MSB
    strobe(8'h01);
    i_sync = 1'b1;
    strobe(8'h5A);
    i_sync = 1'b0;
    check("sw_odd",   o_odd,   1);
    check("sw_count", o_count, 0);
    strobe(8'hA5);
    check("sw_word",  o_word,  16'h5AA5);
    check("sw_count1", o_count, 1);

    // Asynchronous reset mid-operation
    strobe(8'h99);
    check("r_odd1",   o_odd,   1);
    check("r_count1", o_count, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("r_async_odd",   o_odd,   0);
    check("r_async_count", o_count, 0);
    check("r_async_valid", o_valid, 0);
    check("r_async_word",  o_word,  16'h0000);
    tick();
    i_rst = 1'b0;
    tick();
    strobe(8'hAB);
    check("r_odd_after", o_odd, 1);
    strobe(8'hCD);
    check("r_word",  o_word,  16'hABCD);
    check("r_count", o_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_capture_16bit.md
WORD_CAPTURE_16BIT -- requirements
Module: word_capture_16bit

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, log2 of FIFO depth in 16-bit words (DEPTH = 2**DEPTH_LOG2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_v_in  input  8  byte from the processor output port.
REQ-005 SHALL have port i_v_wr  input  1  one-cycle strobe; i_v_in valid this cycle.
REQ-006 SHALL have port i_sync  input  1  forces the byte phase to MSB.
REQ-007 SHALL have port o_word  output  16  FIFO head word, {MSB,LSB}.
REQ-008 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port i_ready  input  1  consumer accepts o_word when o_valid is high.
REQ-010 SHALL have port o_count  output  DEPTH_LOG2+1  words held, 0..DEPTH.
REQ-011 SHALL have port o_odd  output  1  MSB latched, LSB pending.
REQ-012 SHALL have port o_ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port i_clr_ovf  input  1  clears o_ovf.

Function
REQ-014 SHALL use a two-state byte-phase FSM, PH_MSB and PH_LSB; o_odd is high exactly in PH_LSB.
REQ-015 PH_MSB with i_v_wr: SHALL latch i_v_in as MSB and go to PH_LSB.
REQ-016 PH_LSB with i_v_wr: SHALL form {MSB,i_v_in}, request a push, and go to PH_MSB.
REQ-017 i_sync without i_v_wr: SHALL force PH_MSB and discard any latched MSB, with no push.
REQ-018 i_sync with i_v_wr in the same cycle: SHALL take the byte as MSB and go to PH_LSB.
REQ-019 Latency: a pushed word SHALL appear at o_word/o_valid, and in o_count, on the edge after the LSB strobe cycle.
REQ-020 Pop SHALL occur when o_valid && i_ready; o_word SHALL show the next word on the following edge.
REQ-021 o_word SHALL hold its last value when o_valid is low; the bench shall not check it then.
REQ-022 Push and pop in the same cycle with 0 < count <= DEPTH: both SHALL occur and count SHALL be unchanged, including when full.
REQ-023 Push when empty SHALL give count 1; there is no pop that cycle since o_valid was low.
REQ-024 Push when count == DEPTH and no pop: the word SHALL be dropped, count unchanged, and the overflow event asserted.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or go below 0.
REQ-026 Byte strobes SHALL be accepted every cycle back-to-back, giving at most one push per two cycles.

Reset
REQ-027 Asserting i_rst SHALL immediately clear pointers and set o_count=0, o_valid=0, o_odd=0 (PH_MSB), o_ovf=0 and o_word=16'h0000.
REQ-028 Reset mid-operation SHALL discard any pending MSB and all stored words; the first post-reset strobe is an MSB.

Configuration
REQ-029 Macro WORD_CAPTURE_16BIT_OVF_EN defined: o_ovf SHALL set on the edge after an overflow event, stay high until i_clr_ovf, and set-wins if overflow and i_clr_ovf coincide.
REQ-030 Macro WORD_CAPTURE_16BIT_OVF_EN undefined: o_ovf SHALL be constant 0 and i_clr_ovf ignored; drop-on-full behaviour is unchanged.

Verification
REQ-031 Reset, then strobes 8'h12, 8'h34 with i_ready=0 -> o_odd high after the first strobe; o_word=16'h1234, o_valid=1, o_count=1 one edge after the second strobe.
REQ-032 Eight byte pairs 8'h00/8'h01 .. 8'h0E/8'h0F with i_ready=0, then one more pair 8'hAA/8'hBB -> o_count=8, 16'hAABB dropped, o_ovf=1 (macro on) or 0 (off); draining yields 16'h0001..16'h0E0F in order.
REQ-033 Full FIFO, i_ready=1 and push 16'hCAFE in the same cycle -> o_count stays 8, no overflow, 16'hCAFE read last.
REQ-034 Strobe 8'h55, then i_sync pulse, then strobes 8'h66, 8'h77 -> single word 16'h6677, and 8'h55 is never output.
REQ-035 Strobe 8'h99, then i_rst asserted mid-cycle -> o_odd=0 and o_count=0 without waiting for a clock edge; after release, strobes 8'hAB, 8'hCD yield 16'hABCD.
REQ-036 i_clr_ovf pulsed in the same cycle as a new overflow (macro on) -> o_ovf stays 1; pulse alone later -> o_ovf=0.
